// File: rtl/pix_rx_pkg.sv
// Shared definitions for the pixel frame receiver.
//   rx_state_e       : receiver FSM states
//   SOF_BYTE_DEFAULT : default start-of-frame marker
//   cnt_w()          : bits needed to hold 0..max_val (at least 1)
//   img_pix()        : pixel count of a w x h image
package pix_rx_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } rx_state_e;

  localparam logic [7:0] SOF_BYTE_DEFAULT = 8'hA5;

  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int img_pix(input int w, input int h);
    return w * h;
  endfunction

endpackage

// File: rtl/rx_gap_timer.sv
// Inter-byte gap timer. Down-counter reloaded by i_clr; while i_en is high
// it counts towards zero and o_expired flags the terminal count. The
// terminal cycle is the TIMEOUT_CYC-th idle cycle after the last clear.
// Ports:
//   i_clk_sys  system clock
//   i_rst      synchronous active-high reset
//   i_clr      reload counter (byte received / not in a frame)
//   i_en       count enable (inside a frame)
//   o_expired  high in the cycle the gap limit is reached
module rx_gap_timer
  import pix_rx_pkg::*;
#(
  parameter int TIMEOUT_CYC = 5_000_000
) (
  input  logic i_clk_sys,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int             CW   = cnt_w(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0]  LOAD = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = LOAD;
    end else if (i_en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk_sys) begin
    if (i_rst) begin
      cnt_q <= LOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A byte arriving in the terminal cycle restarts the gap instead.
  assign o_expired = i_en && !i_clr && (cnt_q == '0);

endmodule

// File: rtl/pix_frame_rx.sv
// UART pixel frame receiver. Waits for SOF_BYTE, then assembles
// BYTES_PER_PIX bytes (MSB first) per pixel and emits pixel + linear
// address for the frame RAM, with a running XOR checksum per CHK_BLOCK
// pixels, an inter-byte timeout and abort handling.
// Ports:
//   i_clk_sys, i_rst      clock, synchronous active-high reset
//   i_enable              frame reception permitted
//   i_abort               one-cycle request to drop the frame
//   i_rx_data, i_rx_done  received byte and its strobe
//   o_busy                frame in progress
//   o_byte_phase          next expected byte within the pixel
//   o_pix, o_pix_addr     assembled pixel and its index (o_pix_valid)
//   o_chk_data            block XOR checksum (o_chk_valid)
//   o_frame_done          last pixel written
//   o_frame_err           frame aborted (timeout / abort / disable)
//
// state | meaning
// IDLE  | waiting for SOF_BYTE with i_enable high; other bytes ignored
// RECV  | assembling pixels until the last pixel or an abort
module pix_frame_rx
  import pix_rx_pkg::*;
#(
  parameter int         PIX_W         = 12,
  parameter int         BYTES_PER_PIX = 2,
  parameter int         IMG_W         = 160,
  parameter int         IMG_H         = 120,
  parameter int         ADDR_W        = 15,
  parameter int         CHK_BLOCK     = 64,
  parameter int         TIMEOUT_CYC   = 5_000_000,
  parameter logic [7:0] SOF_BYTE      = SOF_BYTE_DEFAULT
) (
  input  logic              i_clk_sys,
  input  logic              i_rst,
  input  logic              i_enable,
  input  logic              i_abort,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_done,
  output logic              o_busy,
  output logic [1:0]        o_byte_phase,
  output logic [PIX_W-1:0]  o_pix,
  output logic              o_pix_valid,
  output logic [ADDR_W-1:0] o_pix_addr,
  output logic [7:0]        o_chk_data,
  output logic              o_chk_valid,
  output logic              o_frame_done,
  output logic              o_frame_err
);

  localparam int                IMG_PIX    = img_pix(IMG_W, IMG_H);
  localparam int                ASM_W      = 8 * BYTES_PER_PIX;
  localparam int                BLK_W      = cnt_w(CHK_BLOCK - 1);
  localparam logic [1:0]        LAST_PHASE = 2'(BYTES_PER_PIX - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(IMG_PIX - 1);
  localparam logic [BLK_W-1:0]  LAST_BLK   = BLK_W'(CHK_BLOCK - 1);

  rx_state_e         state_q;
  logic [1:0]        phase_q;
  logic [ASM_W-1:0]  asm_q;
  logic [7:0]        xor_q;
  logic [ADDR_W-1:0] idx_q;
  logic [BLK_W-1:0]  blk_q;

  logic              busy_q;
  logic [PIX_W-1:0]  pix_q;
  logic              pix_valid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        chk_q;
  logic              chk_valid_q;
  logic              done_q;
  logic              err_q;

  logic [ASM_W-1:0]  asm_d;
  logic [7:0]        xor_d;
  logic              sof_hit;
  logic              abort_req;
  logic              gap_expired;

  always_comb begin
    // Shifting left by a byte per accept leaves the first byte on top;
    // after BYTES_PER_PIX accepts any stale content is shifted out.
    asm_d     = (asm_q << 8) | ASM_W'(i_rx_data);
    xor_d     = xor_q ^ i_rx_data;
    sof_hit   = i_rx_done && i_enable && (i_rx_data == SOF_BYTE);
    abort_req = gap_expired || i_abort || !i_enable;
  end

  rx_gap_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_gap_timer (
    .i_clk_sys (i_clk_sys),
    .i_rst     (i_rst),
    .i_clr     ((state_q == IDLE) || i_rx_done),
    .i_en      (state_q == RECV),
    .o_expired (gap_expired)
  );

  always_ff @(posedge i_clk_sys) begin
    if (i_rst) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      asm_q       <= '0;
      xor_q       <= '0;
      idx_q       <= '0;
      blk_q       <= '0;
      busy_q      <= 1'b0;
      pix_q       <= '0;
      pix_valid_q <= 1'b0;
      addr_q      <= '0;
      chk_q       <= '0;
      chk_valid_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      pix_valid_q <= 1'b0;
      chk_valid_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;

      case (state_q)
        IDLE: begin
          if (sof_hit) begin
            state_q <= RECV;
            busy_q  <= 1'b1;
            phase_q <= '0;
            asm_q   <= '0;
            xor_q   <= '0;
            idx_q   <= '0;
            blk_q   <= '0;
          end
        end

        RECV: begin
          if (abort_req) begin
            // Abort beats a coinciding byte: no pixel or checksum strobe.
            state_q <= IDLE;
            busy_q  <= 1'b0;
            phase_q <= '0;
            err_q   <= 1'b1;
          end else if (i_rx_done) begin
            asm_q <= asm_d;
            if (phase_q == LAST_PHASE) begin
              phase_q     <= '0;
              pix_q       <= asm_d[PIX_W-1:0];
              pix_valid_q <= 1'b1;
              addr_q      <= idx_q;
              if ((blk_q == LAST_BLK) || (idx_q == LAST_IDX)) begin
                chk_q       <= xor_d;
                chk_valid_q <= 1'b1;
                xor_q       <= '0;
                blk_q       <= '0;
              end else begin
                xor_q <= xor_d;
                blk_q <= blk_q + BLK_W'(1);
              end
              if (idx_q == LAST_IDX) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                idx_q <= idx_q + ADDR_W'(1);
              end
            end else begin
              phase_q <= phase_q + 2'd1;
              xor_q   <= xor_d;
            end
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          phase_q <= '0;
        end
      endcase
    end
  end

  assign o_busy       = busy_q;
  assign o_byte_phase = phase_q;
  assign o_pix        = pix_q;
  assign o_pix_valid  = pix_valid_q;
  assign o_pix_addr   = addr_q;
  assign o_chk_data   = chk_q;
  assign o_chk_valid  = chk_valid_q;
  assign o_frame_done = done_q;
  assign o_frame_err  = err_q;

endmodule

// File: tb/tb_pix_frame_rx.sv
// Bench for pix_frame_rx: three instances (12b/2 bytes, 16b/2 bytes,
// 24b/3 bytes) share one byte stream. A per-instance reference model
// predicts every output strobe cycle into a queue; a negedge monitor
// pops and compares, and checks o_busy / o_byte_phase every cycle.
module tb_pix_frame_rx;

  localparam int TMO  = 100;
  localparam int NPIX = 8;
  localparam int CHKB = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       abrt = 1'b0;
  logic       rx_done = 1'b0;
  logic [7:0] rx_data = 8'h00;

  always #5 clk = ~clk;

  logic        busy_a, pv_a, cv_a, done_a, err_a;
  logic [1:0]  ph_a;
  logic [11:0] pix_a;
  logic [2:0]  addr_a;
  logic [7:0]  chk_a;
  logic        busy_b, pv_b, cv_b, done_b, err_b;
  logic [1:0]  ph_b;
  logic [15:0] pix_b;
  logic [2:0]  addr_b;
  logic [7:0]  chk_b;
  logic        busy_c, pv_c, cv_c, done_c, err_c;
  logic [1:0]  ph_c;
  logic [23:0] pix_c;
  logic [2:0]  addr_c;
  logic [7:0]  chk_c;

  pix_frame_rx #(.PIX_W(12), .BYTES_PER_PIX(2), .IMG_W(4), .IMG_H(2), .ADDR_W(3),
                 .CHK_BLOCK(CHKB), .TIMEOUT_CYC(TMO), .SOF_BYTE(8'hA5)) dut_a (
    .i_clk_sys(clk), .i_rst(rst), .i_enable(en), .i_abort(abrt),
    .i_rx_data(rx_data), .i_rx_done(rx_done), .o_busy(busy_a), .o_byte_phase(ph_a),
    .o_pix(pix_a), .o_pix_valid(pv_a), .o_pix_addr(addr_a), .o_chk_data(chk_a),
    .o_chk_valid(cv_a), .o_frame_done(done_a), .o_frame_err(err_a));

  pix_frame_rx #(.PIX_W(16), .BYTES_PER_PIX(2), .IMG_W(4), .IMG_H(2), .ADDR_W(3),
                 .CHK_BLOCK(CHKB), .TIMEOUT_CYC(TMO), .SOF_BYTE(8'hA5)) dut_b (
    .i_clk_sys(clk), .i_rst(rst), .i_enable(en), .i_abort(abrt),
    .i_rx_data(rx_data), .i_rx_done(rx_done), .o_busy(busy_b), .o_byte_phase(ph_b),
    .o_pix(pix_b), .o_pix_valid(pv_b), .o_pix_addr(addr_b), .o_chk_data(chk_b),
    .o_chk_valid(cv_b), .o_frame_done(done_b), .o_frame_err(err_b));

  pix_frame_rx #(.PIX_W(24), .BYTES_PER_PIX(3), .IMG_W(4), .IMG_H(2), .ADDR_W(3),
                 .CHK_BLOCK(CHKB), .TIMEOUT_CYC(TMO), .SOF_BYTE(8'hA5)) dut_c (
    .i_clk_sys(clk), .i_rst(rst), .i_enable(en), .i_abort(abrt),
    .i_rx_data(rx_data), .i_rx_done(rx_done), .o_busy(busy_c), .o_byte_phase(ph_c),
    .o_pix(pix_c), .o_pix_valid(pv_c), .o_pix_addr(addr_c), .o_chk_data(chk_c),
    .o_chk_valid(cv_c), .o_frame_done(done_c), .o_frame_err(err_c));

  typedef struct {
    longint     cyc;
    logic       pv;
    logic [23:0] pix;
    int         addr;
    logic       cv;
    logic [7:0] chk;
    logic       done;
    logic       err;
  } exp_t;

  exp_t exq[3][$];

  int checks = 0;
  int errors = 0;
  longint cyc = 0;

  int          bpp_c[3] = '{2, 2, 3};
  int          pw_c[3]  = '{12, 16, 24};
  bit          busy_m[3];
  logic [63:0] acc_m[3];
  int          nb_m[3];
  int          pc_m[3];
  int          bc_m[3];
  logic [7:0]  xr_m[3];
  longint      last_m[3];

  // Reference: a frame is a list of bytes; every bpp bytes form one
  // big-endian number, truncated to the pixel width.
  task automatic model_step(input int m);
    exp_t e;
    bit   ev;
    ev = 1'b0;
    e.cyc = cyc + 1; e.pv = 0; e.pix = 0; e.addr = 0;
    e.cv = 0; e.chk = 0; e.done = 0; e.err = 0;
    if (rst) begin
      busy_m[m] = 0;
      nb_m[m] = 0;
      return;
    end
    if (!busy_m[m]) begin
      if (rx_done && en && rx_data == 8'hA5) begin
        busy_m[m] = 1; nb_m[m] = 0; acc_m[m] = 0; pc_m[m] = 0;
        bc_m[m] = 0; xr_m[m] = 0; last_m[m] = cyc;
      end
    end else if (abrt || !en || (!rx_done && (cyc - last_m[m] >= TMO))) begin
      busy_m[m] = 0;
      nb_m[m] = 0;
      e.err = 1;
      ev = 1'b1;
    end else if (rx_done) begin
      last_m[m] = cyc;
      acc_m[m] = acc_m[m] * 256 + 64'(rx_data);
      xr_m[m] = xr_m[m] ^ rx_data;
      nb_m[m]++;
      if (nb_m[m] == bpp_c[m]) begin
        e.pv = 1;
        e.pix = 24'(acc_m[m] % (64'd1 << pw_c[m]));
        e.addr = pc_m[m];
        bc_m[m]++;
        if (bc_m[m] == CHKB || pc_m[m] == NPIX - 1) begin
          e.cv = 1; e.chk = xr_m[m]; xr_m[m] = 0; bc_m[m] = 0;
        end
        if (pc_m[m] == NPIX - 1) begin
          e.done = 1;
          busy_m[m] = 0;
        end
        pc_m[m]++;
        nb_m[m] = 0;
        acc_m[m] = 0;
        ev = 1'b1;
      end
    end
    if (ev) exq[m].push_back(e);
  endtask

  always @(posedge clk) begin
    for (int m = 0; m < 3; m++) model_step(m);
    cyc = cyc + 1;
  end

  task automatic check_inst(input int m, input logic pv, input logic [23:0] pix,
                            input int addr, input logic cv, input logic [7:0] chk,
                            input logic done, input logic err, input logic busy,
                            input int ph);
    exp_t e;
    while (exq[m].size() > 0 && exq[m][0].cyc < cyc) begin
      e = exq[m].pop_front();
      checks++; errors++;
      $display("FAIL missed_strobe inst%0d cyc=%0d: nothing seen, expected pv=%0b cv=%0b done=%0b err=%0b",
               m, e.cyc, e.pv, e.cv, e.done, e.err);
    end
    if (exq[m].size() > 0 && exq[m][0].cyc == cyc) begin
      e = exq[m].pop_front();
      checks++;
      if (pv !== e.pv || cv !== e.cv || done !== e.done || err !== e.err ||
          (e.pv && (pix !== e.pix || addr != e.addr)) || (e.cv && chk !== e.chk)) begin
        errors++;
        $display("FAIL strobe inst%0d cyc=%0d: got pv=%0b pix=%h addr=%0d cv=%0b chk=%h done=%0b err=%0b, expected pv=%0b pix=%h addr=%0d cv=%0b chk=%h done=%0b err=%0b",
                 m, cyc, pv, pix, addr, cv, chk, done, err,
                 e.pv, e.pix, e.addr, e.cv, e.chk, e.done, e.err);
      end
    end else if (pv !== 1'b0 || cv !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      checks++; errors++;
      $display("FAIL unexpected_strobe inst%0d cyc=%0d: got pv=%0b cv=%0b done=%0b err=%0b, expected none",
               m, cyc, pv, cv, done, err);
    end
    checks++;
    if (busy !== busy_m[m] || ph != nb_m[m]) begin
      errors++;
      $display("FAIL busy_phase inst%0d cyc=%0d: got busy=%0b phase=%0d, expected busy=%0b phase=%0d",
               m, cyc, busy, ph, busy_m[m], nb_m[m]);
    end
  endtask

  always @(negedge clk) begin
    check_inst(0, pv_a, 24'(pix_a), int'(addr_a), cv_a, chk_a, done_a, err_a, busy_a, int'(ph_a));
    check_inst(1, pv_b, 24'(pix_b), int'(addr_b), cv_b, chk_b, done_b, err_b, busy_b, int'(ph_b));
    check_inst(2, pv_c, pix_c, int'(addr_c), cv_c, chk_c, done_c, err_c, busy_c, int'(ph_c));
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input int gap);
    rx_data = d;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    abrt = 1'b0;
    repeat (gap) tick();
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    en = 1'b1;
    tick();

    @(negedge clk);
    checks++;
    if (pix_a !== 12'h0 || addr_a !== 3'd0 || chk_a !== 8'h0 ||
        pix_c !== 24'h0 || addr_c !== 3'd0 || chk_c !== 8'h0) begin
      errors++;
      $display("FAIL reset_data: got pix_a=%h addr_a=%0d chk_a=%h pix_c=%h, expected all zero",
               pix_a, addr_a, chk_a, pix_c);
    end
    tick();

    // First pixels: 0F AB -> FAB, 01 23 -> 123; then abort.
    send(8'hA5, 1); send(8'h0F, 1); send(8'hAB, 2);
    send(8'h01, 0); send(8'h23, 3);
    abrt = 1'b1; tick(); abrt = 1'b0;
    repeat (3) tick();

    // Full frame: bytes k, k+1 for k = 0, 2, .., 14.
    send(8'hA5, 1);
    for (int k = 0; k < 16; k += 2) begin
      send(8'(k), $urandom_range(0, 2));
      send(8'(k + 1), $urandom_range(0, 2));
    end
    repeat (120) tick();

    // IDLE garbage, SOF while disabled, then timeout of a real frame.
    send(8'h00, 1); send(8'hFF, 1); send(8'h5A, 1);
    en = 1'b0;
    send(8'hA5, 2);
    en = 1'b1;
    tick();
    send(8'hA5, 1); send(8'h0F, 0);
    repeat (130) tick();

    // Restart at address 0 after timeout.
    send(8'hA5, 1); send(8'h12, 0); send(8'h34, 2);
    abrt = 1'b1; tick(); abrt = 1'b0; tick();
    send(8'hA5, 1); send(8'hAB, 0); send(8'hCD, 0); send(8'hEF, 3);
    abrt = 1'b1; tick(); abrt = 1'b0; tick();

    // Abort coinciding with a pixel-completing byte; enable drop mid-frame.
    send(8'hA5, 1); send(8'h11, 1);
    abrt = 1'b1;
    send(8'h22, 2);
    send(8'hA5, 1); send(8'h33, 1);
    en = 1'b0; tick(); en = 1'b1;
    repeat (2) tick();

    // Back-to-back bytes, every cycle.
    send(8'hA5, 0);
    for (int b = 0; b < 24; b++) send(8'($urandom), 0);
    repeat (150) tick();

    // Reset mid-frame: no error strobe.
    send(8'hA5, 1); send(8'h44, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (2) tick();

    // Randomized traffic with SOFs, gaps, timeouts, aborts and disables.
    for (int it = 0; it < 30; it++) begin
      int nbytes;
      nbytes = $urandom_range(4, 30);
      for (int b = 0; b < nbytes; b++) begin
        logic [7:0] d;
        int         r;
        int         g;
        r = $urandom_range(0, 99);
        d = (r < 15) ? 8'hA5 : 8'($urandom);
        g = (r == 99) ? 101 : $urandom_range(0, 3);
        if (r == 98) abrt = 1'b1;
        send(d, g);
        if (r == 97) begin
          en = 1'b0; tick(); en = 1'b1;
        end
      end
    end
    repeat (200) tick();

    for (int m = 0; m < 3; m++) begin
      checks++;
      if (exq[m].size() != 0) begin
        errors++;
        $display("FAIL leftover inst%0d: got %0d pending expected strobes, expected 0",
                 m, exq[m].size());
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pix_frame_rx.md
Name: pix_frame_rx

Overview:
Parametrised successor to the fixed two-byte/12-bit pixel receiver. Takes the UART receive byte stream and detects a start-of-frame byte. Assembles BYTES_PER_PIX bytes per pixel of PIX_W bits and emits pixel+address for the frame RAM. Adds per-block XOR checksum replies, inter-byte timeout, abort, and frame-complete/error pulses.

Parameters:
PIX_W, 12, pixel width in bits; must be <= 8*BYTES_PER_PIX.
BYTES_PER_PIX, 2, bytes per pixel, first byte received = most significant (1..4).
IMG_W, 160, image width in pixels.
IMG_H, 120, image height in pixels; IMG_PIX = IMG_W*IMG_H.
ADDR_W, 15, address width; must satisfy 2**ADDR_W >= IMG_PIX.
CHK_BLOCK, 64, pixels per checksum block (>= 1).
TIMEOUT_CYC, 5_000_000, idle clock cycles within a frame before abort (100 ms at 50 MHz).
SOF_BYTE, 8'hA5, start-of-frame marker.

Ports:
i_clk_sys  in  1  system clock, 50 MHz; single clock domain.
i_rst  in  1  synchronous, active-high reset.
i_enable  in  1  frame reception permitted (system state = image receive).
i_abort  in  1  one-cycle request to drop the current frame.
i_rx_data  in  8  received UART byte.
i_rx_done  in  1  one-cycle strobe, i_rx_data valid.
o_busy  out  1  high from SOF accepted until frame end/abort.
o_byte_phase  out  2  index of next expected byte within pixel.
o_pix  out  PIX_W  assembled pixel.
o_pix_valid  out  1  one-cycle strobe for o_pix/o_pix_addr.
o_pix_addr  out  ADDR_W  linear pixel index 0..IMG_PIX-1.
o_chk_data  out  8  XOR of all bytes in completed block.
o_chk_valid  out  1  one-cycle strobe for o_chk_data.
o_frame_done  out  1  one-cycle strobe, last pixel written.
o_frame_err  out  1  one-cycle strobe, frame aborted (timeout/abort/disable).

Behaviour:
- Reset: all outputs 0; state IDLE; counters, byte phase, shift register, XOR accumulator cleared. Reset mid-frame discards the frame without o_frame_err.
- States: IDLE, RECV. All outputs registered.
- IDLE: i_rx_done && i_enable && i_rx_data==SOF_BYTE -> RECV, o_busy=1 next cycle, pixel index=0, phase=0, XOR=0, timer=0. Any other byte is ignored. No byte in IDLE produces any strobe.
- RECV byte accept: on i_rx_done, shift byte into the assembly register and XOR it into the accumulator. SOF_BYTE value is plain data here.
- Pixel completion: if phase==BYTES_PER_PIX-1, then on the next cycle assert o_pix_valid with o_pix = low PIX_W bits of the concatenated bytes and o_pix_addr = index. Phase then returns to 0 and index increments. Otherwise phase increments. Latency: last byte's i_rx_done at cycle N -> strobe at N+1.
- Back-to-back i_rx_done on consecutive cycles must all be accepted.
- Block checksum: when the completed pixel is the CHK_BLOCK-th of its block, or is pixel IMG_PIX-1, assert o_chk_valid at N+1 (same cycle as o_pix_valid) with the final XOR. The accumulator then clears. A final partial block still gets a checksum.
- Frame end: pixel IMG_PIX-1 completes -> o_frame_done at N+1; state IDLE; o_busy=0 the same cycle.
- Timer: counts cycles in RECV, cleared on every i_rx_done. Reaching TIMEOUT_CYC-1 -> abort.
- Abort sources: timeout, i_abort, or i_enable low while in RECV. Each gives o_frame_err for one cycle, state IDLE, partial pixel discarded, no pixel/chk strobe that cycle. If an abort coincides with a completing i_rx_done, the abort wins.
- Index never wraps: the frame ends exactly at IMG_PIX-1.
- o_byte_phase reads 0 in IDLE.

Decomposition:
- Package pix_rx_pkg holds: state enum (IDLE, RECV), SOF_BYTE default, clog2-based width helper, and IMG_PIX derivation.
- One sub-module, rx_gap_timer: parametrised TIMEOUT_CYC counter with clear/enable inputs and an expired pulse output.
- Byte assembly, checksum, and FSM stay in pix_frame_rx.

Test Plan:
- Small params (IMG_W=4, IMG_H=2, CHK_BLOCK=3, PIX_W=12, BYTES=2). Send A5 then 0F AB -> o_pix=12'hFAB, addr 0 at N+1. Bytes 01 23 -> 12'h123, addr 1.
- Full small frame of 8 pixels, bytes k,k+1 for k=0,2,..,14 -> o_chk_valid after pixels 2, 5, 7 with data 01, 01 and 00 (partial block). o_frame_done with pixel 7; o_busy falls.
- IDLE garbage: bytes 00 FF 5A, then A5 with i_enable=0 -> no strobes, o_busy stays 0. A5 with i_enable=1 -> o_busy=1.
- TIMEOUT_CYC=100: A5 0F, then silence -> o_frame_err exactly 100 cycles after the last i_rx_done. State IDLE; a following A5 restarts at addr 0.
- i_abort in the same cycle as a pixel-completing i_rx_done -> o_frame_err=1, o_pix_valid=0. Deassert i_enable mid-frame -> o_frame_err.
- PIX_W=16, BYTES_PER_PIX=2: A5 12 34 -> 16'h1234. Then PIX_W=24, BYTES_PER_PIX=3: A5 AB CD EF -> 24'hABCDEF. Back-to-back i_rx_done each cycle -> all pixels captured.
